// File: rtl/fetch_decode_fifo.sv
// Multi-lane fetch-to-decode instruction queue: compacting multi-lane push,
// in-order multi-lane pop, flush, all outputs driven from registered state only.
package fetch_decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_decode_pack_t;
endpackage

module fetch_decode_fifo
  import fetch_decode_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [FETCH_WIDTH-1:0]     fetch_decode_fifo_data_in_enable,
  input  fetch_decode_pack_t         fetch_decode_fifo_data_in [0:FETCH_WIDTH-1],
  input  logic [FETCH_WIDTH-1:0]     fetch_decode_fifo_data_in_valid,
  input  logic                       fetch_decode_fifo_push,
  input  logic                       fetch_decode_fifo_flush,
  output fetch_decode_pack_t         fetch_decode_fifo_data_out [0:DECODE_WIDTH-1],
  output logic [DECODE_WIDTH-1:0]    fetch_decode_fifo_data_out_valid,
  input  logic [DECODE_WIDTH-1:0]    decode_fetch_decode_fifo_pop,
  output logic [$clog2(DEPTH):0]     fetch_decode_fifo_count,
  output logic                       fetch_decode_fifo_empty,
  output logic                       fetch_decode_fifo_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_decode_pack_t mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   n_push, n_pop;
  logic [FETCH_WIDTH-1:0] accept;
  logic [PTR_W-1:0]   wr_idx [FETCH_WIDTH];
  logic               pop_run;

  assign free_slots = CNT_W'(DEPTH) - count;

  // Enable uses registered occupancy only; same-cycle pops give no credit.
  always_comb begin
    fetch_decode_fifo_data_in_enable = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      fetch_decode_fifo_data_in_enable[i] = free_slots > CNT_W'(i);
  end

  // Accepted lanes are packed into consecutive slots starting at wr_ptr.
  always_comb begin
    n_push = '0;
    accept = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      accept[i] = fetch_decode_fifo_push && !fetch_decode_fifo_flush &&
                  fetch_decode_fifo_data_in_valid[i] &&
                  fetch_decode_fifo_data_in_enable[i];
      wr_idx[i] = wr_ptr + n_push[PTR_W-1:0];
      if (accept[i]) n_push = n_push + CNT_W'(1);
    end
  end

  // Pops retire only a contiguous run from lane 0.
  always_comb begin
    n_pop   = '0;
    pop_run = 1'b1;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (pop_run && decode_fetch_decode_fifo_pop[i] && fetch_decode_fifo_data_out_valid[i])
        n_pop = n_pop + CNT_W'(1);
      else
        pop_run = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      fetch_decode_fifo_data_out[i]       = mem[rd_ptr + PTR_W'(i)];
      fetch_decode_fifo_data_out_valid[i] = count > CNT_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (accept[i] && !rst) mem[wr_idx[i]] <= fetch_decode_fifo_data_in[i];
  end

  always_ff @(posedge clk) begin
    if (rst || fetch_decode_fifo_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      rd_ptr <= rd_ptr + n_pop[PTR_W-1:0];
      count  <= count + n_push - n_pop;
    end
  end

  assign fetch_decode_fifo_count = count;
  assign fetch_decode_fifo_empty = (count == '0);
  assign fetch_decode_fifo_full  = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_decode_fifo.sv
// Directed-vector bench for fetch_decode_fifo at 4/4/16 geometry.
module tb_fetch_decode_fifo;
  import fetch_decode_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         din_en;
  fetch_decode_pack_t din [0:3];
  logic [3:0]         din_valid;
  logic               push;
  logic               flush;
  fetch_decode_pack_t dout [0:3];
  logic [3:0]         dout_valid;
  logic [3:0]         pop;
  logic [4:0]         count;
  logic               empty, full;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_decode_fifo #(.FETCH_WIDTH(4), .DECODE_WIDTH(4), .DEPTH(16)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .fetch_decode_fifo_data_in_enable (din_en),
    .fetch_decode_fifo_data_in        (din),
    .fetch_decode_fifo_data_in_valid  (din_valid),
    .fetch_decode_fifo_push           (push),
    .fetch_decode_fifo_flush          (flush),
    .fetch_decode_fifo_data_out       (dout),
    .fetch_decode_fifo_data_out_valid (dout_valid),
    .decode_fetch_decode_fifo_pop     (pop),
    .fetch_decode_fifo_count          (count),
    .fetch_decode_fifo_empty          (empty),
    .fetch_decode_fifo_full           (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then return to idle 1 ns after the edge.
  task automatic cyc(input logic p, input logic [3:0] v, input logic [31:0] base,
                     input logic [3:0] pp, input logic f, input logic r);
    push      = p;
    din_valid = v;
    for (int i = 0; i < 4; i++) begin
      din[i].pc    = base + 32'(4 * i);
      din[i].instr = ~(base + 32'(4 * i));
    end
    pop   = pp;
    flush = f;
    rst   = r;
    @(posedge clk);
    #1;
    push = 1'b0; din_valid = '0; pop = '0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; flush = 1'b0; pop = '0; din_valid = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    @(posedge clk); #1;
    cyc(0, 4'b0000, 0, 4'b0000, 0, 1);

    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full",  64'(full), 0);
    chk("rst_en",    64'(din_en), 64'hF);
    chk("rst_ovld",  64'(dout_valid), 0);

    // First push: nothing visible until the following cycle.
    push = 1'b1; din_valid = 4'hF;
    chk("lat_en_same",   64'(din_en), 64'hF);
    chk("lat_ovld_same", 64'(dout_valid), 0);
    cyc(1, 4'b1111, 32'h8000_0000, 4'b0000, 0, 0);
    chk("p1_count", 64'(count), 4);
    chk("p1_ovld",  64'(dout_valid), 64'hF);
    chk("p1_out0",  64'(dout[0].pc), 64'h8000_0000);
    chk("p1_out3",  64'(dout[3].pc), 64'h8000_000C);
    chk("p1_instr", 64'(dout[2].instr), 64'h7FFF_FFF7);

    cyc(1, 4'b1111, 32'h8000_0010, 4'b0000, 0, 0);
    cyc(1, 4'b1111, 32'h8000_0020, 4'b0000, 0, 0);
    cyc(1, 4'b1111, 32'h8000_0030, 4'b0000, 0, 0);
    chk("full_count", 64'(count), 16);
    chk("full_flag",  64'(full), 1);
    chk("full_en",    64'(din_en), 0);

    cyc(1, 4'b1111, 32'hDEAD_0000, 4'b0000, 0, 0);
    chk("ovf_count", 64'(count), 16);
    chk("ovf_out0",  64'(dout[0].pc), 64'h8000_0000);
    chk("ovf_out3",  64'(dout[3].pc), 64'h8000_000C);

    cyc(0, 4'b0000, 0, 4'b0011, 0, 0);
    chk("c14_count", 64'(count), 14);
    chk("c14_en",    64'(din_en), 64'h3);
    chk("c14_out0",  64'(dout[0].pc), 64'h8000_0008);

    cyc(1, 4'b1111, 32'h9000_0000, 4'b0000, 0, 0);
    chk("part_count", 64'(count), 16);

    // Drain 12 so rd_ptr sits at 14 with the read window wrapping.
    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    chk("wrap_count", 64'(count), 4);
    chk("wrap_out0",  64'(dout[0].pc), 64'h8000_0038);
    chk("wrap_out1",  64'(dout[1].pc), 64'h8000_003C);
    chk("wrap_out2",  64'(dout[2].pc), 64'h9000_0000);
    chk("wrap_out3",  64'(dout[3].pc), 64'h9000_0004);

    cyc(0, 4'b0000, 0, 4'b1011, 0, 0);
    chk("gap_count", 64'(count), 2);
    chk("gap_out0",  64'(dout[0].pc), 64'h9000_0000);
    chk("gap_ovld",  64'(dout_valid), 64'h3);

    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    chk("drain_count", 64'(count), 0);
    chk("drain_empty", 64'(empty), 1);

    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    chk("popempty_count", 64'(count), 0);

    cyc(1, 4'b0111, 32'hA000_0000, 4'b0000, 0, 0);
    chk("c3_count", 64'(count), 3);
    cyc(1, 4'b1111, 32'hB000_0000, 4'b0011, 0, 0);
    chk("pp_count", 64'(count), 5);
    chk("pp_out0",  64'(dout[0].pc), 64'hA000_0008);
    chk("pp_out1",  64'(dout[1].pc), 64'hB000_0000);

    cyc(1, 4'b0101, 32'hC000_0000, 4'b0000, 0, 0);
    chk("sparse_count", 64'(count), 7);
    cyc(0, 4'b0000, 0, 4'b1111, 0, 0);
    chk("cmp_out0", 64'(dout[0].pc), 64'hB000_000C);
    chk("cmp_out1", 64'(dout[1].pc), 64'hC000_0000);
    chk("cmp_out2", 64'(dout[2].pc), 64'hC000_0008);
    chk("cmp_ovld", 64'(dout_valid), 64'h7);

    cyc(1, 4'b1111, 32'hD000_0000, 4'b0000, 0, 0);
    cyc(1, 4'b0111, 32'hD000_0010, 4'b0000, 0, 0);
    chk("c10_count", 64'(count), 10);
    cyc(1, 4'b1111, 32'hEEEE_0000, 4'b1111, 1, 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_ovld",  64'(dout_valid), 0);
    chk("flush_en",    64'(din_en), 64'hF);
    chk("flush_empty", 64'(empty), 1);

    cyc(1, 4'b0001, 32'hE000_0000, 4'b0000, 0, 0);
    chk("pf_count", 64'(count), 1);
    chk("pf_out0",  64'(dout[0].pc), 64'hE000_0000);

    cyc(1, 4'b1111, 32'hF000_0000, 4'b0000, 0, 0);
    cyc(1, 4'b0011, 32'hF000_0010, 4'b0000, 0, 0);
    chk("c7_count", 64'(count), 7);
    cyc(1, 4'b1111, 32'h1111_0000, 4'b1111, 0, 1);
    chk("mrst_count", 64'(count), 0);
    chk("mrst_ovld",  64'(dout_valid), 0);
    chk("mrst_en",    64'(din_en), 64'hF);
    chk("mrst_full",  64'(full), 0);
    chk("mrst_empty", 64'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_decode_fifo.md
FETCH_DECODE_FIFO -- requirements
Module: fetch_decode_fifo

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: number of push lanes per cycle.
REQ-002 Parameter DECODE_WIDTH, default 4: number of read/pop lanes per cycle.
REQ-003 Parameter DEPTH, default 16: entry count; power of two, and at least max(FETCH_WIDTH, DECODE_WIDTH).
REQ-004 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 fetch_decode_fifo_data_in_enable  output  FETCH_WIDTH  bit i = room for lane i this cycle.
REQ-008 fetch_decode_fifo_data_in  input  fetch_decode_pack_t[0:FETCH_WIDTH-1]  push payload.
REQ-009 fetch_decode_fifo_data_in_valid  input  FETCH_WIDTH  per-lane payload valid.
REQ-010 fetch_decode_fifo_push  input  1  push strobe.
REQ-011 fetch_decode_fifo_flush  input  1  discard all entries.
REQ-012 fetch_decode_fifo_data_out  output  fetch_decode_pack_t[0:DECODE_WIDTH-1]  oldest entries, lane 0 oldest.
REQ-013 fetch_decode_fifo_data_out_valid  output  DECODE_WIDTH  per-lane output valid.
REQ-014 decode_fetch_decode_fifo_pop  input  DECODE_WIDTH  per-lane pop request.
REQ-015 fetch_decode_fifo_count  output  clog2(DEPTH)+1  occupied entries.
REQ-016 fetch_decode_fifo_empty / fetch_decode_fifo_full  output  1 each  count==0 / count==DEPTH.

Function
REQ-017 State: rd_ptr, wr_ptr (clog2(DEPTH) bits, modulo-DEPTH wrap) and count; entry storage is not reset.
REQ-018 data_in_enable[i] SHALL be 1 iff (DEPTH-count) > i; it uses registered count only, with no credit from same-cycle pops.
REQ-019 Lane i is accepted iff push && !flush && data_in_valid[i] && data_in_enable[i].
REQ-020 Accepted lanes SHALL be written in ascending lane order to wr_ptr, wr_ptr+1, ... (compacted).
REQ-021 wr_ptr and count SHALL advance by the number of accepted lanes (n_push).
REQ-022 Valid lanes that lack enable SHALL be silently dropped; this is not an error state.
REQ-023 data_out[i] = entry[(rd_ptr+i) mod DEPTH] and data_out_valid[i] = (count > i); both combinational from registered state.
REQ-024 n_pop = number of consecutive lanes from lane 0 with pop[i] && data_out_valid[i]; pop bits above the first gap SHALL be ignored.
REQ-025 rd_ptr SHALL advance by n_pop; count SHALL become count + n_push - n_pop.
REQ-026 Push-to-output latency SHALL be exactly 1 cycle, with no same-cycle bypass when empty.
REQ-027 Simultaneous push and pop SHALL both take effect in the same edge, with FIFO order preserved.
REQ-028 A push while full SHALL write nothing; a pop while empty SHALL change nothing.
REQ-029 Flush SHALL have priority over push and pop: next cycle rd_ptr=wr_ptr=0, count=0.
REQ-030 Outputs SHALL be glitch-free functions of registered state only; the interface has no input-to-output combinational path.

Reset
REQ-031 rst asserted at an edge SHALL set rd_ptr=0, wr_ptr=0 and count=0, overriding push, pop and flush.
REQ-032 After reset: data_in_enable all ones, data_out_valid=0, count=0, empty=1, full=0.
REQ-033 Reset mid-operation SHALL discard all entries, with identical post-reset state.

Verification (FETCH_WIDTH=4, DECODE_WIDTH=4, DEPTH=16)
REQ-034 Reset, then push valid=1111 with pc 0x80000000..0x8000000C -> same cycle: enable=1111, out_valid=0000; next cycle: count=4, out_valid=1111, out[0].pc=0x80000000, out[3].pc=0x8000000C.
REQ-035 Four pushes of 4, no pop -> count=16, full=1, enable=0000; a further push of valid=1111 -> count stays 16, contents unchanged.
REQ-036 At count=14, push valid=1111 -> only lanes 0,1 written, count=16; at count=3, push 4 with pop=0011 -> count=5, out[0] = former entry 2.
REQ-037 rd_ptr=14 with count=4 -> out lanes show entries 14,15,0,1 in order; pop=1111 -> rd_ptr=2, empty=1; pop=1011 at count=4 -> n_pop=2.
REQ-038 At count=10, flush with push and pop both asserted -> next cycle count=0, out_valid=0000, enable=1111; rst at count=7 -> same result.
